fwd_hazard_unit: RTL

//  Parametrised forwarding + hazard controller for the pipelined CPU core.

---
 rtl/fwd_hazard_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use detect and single long-op countdown scoreboard.
// Latency: forwarding/stall combinational (0 cycles); scoreboard state registered (1 cycle).
// Backpressure: stall_o freezes PC/IF-ID; optional FWD_STATS_EN adds saturating stall/forward counters.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_STG  = 2,
    parameter int LONG_LAT = 4,
    localparam int SW      = $clog2(NUM_STG + 1),
    localparam int CW      = $clog2(LONG_LAT) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs_i,
    input  logic                        id_long_i,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs_i,
    input  logic [NUM_STG-1:0]          stg_we_i,
    input  logic [NUM_STG*REG_AW-1:0]   stg_rd_i,
    input  logic                        idex_load_i,
    input  logic [REG_AW-1:0]           idex_rd_i,
    input  logic                        long_start_i,
    input  logic [REG_AW-1:0]           long_rd_i,
    output logic [NUM_SRC*SW-1:0]       fwd_sel_o,
    output logic                        stall_o,
    output logic                        long_busy_o,
    output logic                        long_done_o,
    output logic                        long_ovf_o
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]                 stall_cnt_o,
    output logic [15:0]                 fwd_cnt_o
`endif
);

    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] busy_rd_q, busy_rd_d;
    logic              ovf_q, ovf_d;

    logic              cnt_zero;
    logic              lu_stall;
    logic              sb_stall;

    assign cnt_zero = (cnt_q == '0);

    // Youngest stage wins: scan oldest to youngest so the last hit overrides.
    always_comb begin
        fwd_sel_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (stg_we_i[k]
                    && (stg_rd_i[k*REG_AW +: REG_AW] != '0)
                    && (stg_rd_i[k*REG_AW +: REG_AW] == ex_rs_i[s*REG_AW +: REG_AW])) begin
                    fwd_sel_o[s*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        lu_stall = 1'b0;
        sb_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (idex_load_i && (idex_rd_i != '0)
                && (id_rs_i[s*REG_AW +: REG_AW] == idex_rd_i)) begin
                lu_stall = 1'b1;
            end
            if (busy_q && (busy_rd_q != '0)
                && (id_rs_i[s*REG_AW +: REG_AW] == busy_rd_q)) begin
                sb_stall = 1'b1;
            end
        end
        // Only one long unit: a second long op must wait unless the current one retires now.
        if (id_long_i && busy_q && !cnt_zero) begin
            sb_stall = 1'b1;
        end
    end

    assign stall_o     = lu_stall | sb_stall;
    assign long_busy_o = busy_q;
    assign long_done_o = busy_q & cnt_zero;
    assign long_ovf_o  = ovf_q;

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        busy_rd_d = busy_rd_q;
        ovf_d     = ovf_q;
        if (!busy_q || cnt_zero) begin
            // Idle, or retiring this cycle: a start here is accepted back-to-back.
            busy_d = long_start_i;
            if (long_start_i) begin
                cnt_d     = CW'(LONG_LAT - 1);
                busy_rd_d = long_rd_i;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (long_start_i) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            busy_rd_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            busy_rd_q <= busy_rd_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((|fwd_sel_o) && (fwd_cnt_q != 16'hFFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule
